// File: rtl/program_counter.sv
// Program counter register: holds the current fetch address and loads the
// externally computed next PC on every rising clock edge.
module program_counter #(
  parameter int          N            = 64,
  parameter logic [N-1:0] RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] PC_in,
  output logic [N-1:0] PC_out
);

  logic [N-1:0] pc_reg;

  // rst is active-low and only takes effect at the clock edge; no enable, so
  // the register updates every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= PC_in;
    end
  end

  assign PC_out = pc_reg;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_program_counter;

  localparam int          N       = 64;
  localparam logic [N-1:0] ALT_VEC = 64'h0000_0000_8000_0000;

  logic         clk;
  logic         rst;
  logic [N-1:0] PC_in;
  logic [N-1:0] PC_out;
  logic [N-1:0] PC_out_alt;

  int tests_run = 0;
  int tests_failed = 0;

  program_counter #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .PC_in (PC_in),
    .PC_out(PC_out)
  );

  program_counter #(.N(N), .RESET_VECTOR(ALT_VEC)) dut_alt (
    .clk   (clk),
    .rst   (rst),
    .PC_in (PC_in),
    .PC_out(PC_out_alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs between edges, clock once, sample 1 ns after the edge.
  task automatic step(input logic r, input logic [N-1:0] v);
    rst   = r;
    PC_in = v;
    @(posedge clk);
    #1;
  endtask

  // Reference: what the PC should hold after an edge given the inputs at it.
  function automatic logic [N-1:0] model_next(input logic r, input logic [N-1:0] v,
                                              input logic [N-1:0] vec);
    return r ? v : vec;
  endfunction

  logic [N-1:0] held;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_alt_q[$];

  initial begin
    rst   = 1'b0;
    PC_in = '0;
    @(negedge clk);

    step(1'b0, 64'h1234);
    check("reset_default", PC_out, 64'h0);
    check("reset_alt_vec", PC_out_alt, ALT_VEC);
    $display("[TB] reset pc_in=1234 -> pc_out=%h", PC_out);

    step(1'b1, 64'h4);
    check("load_4", PC_out, 64'h4);
    step(1'b1, 64'h8);
    check("load_8", PC_out, 64'h8);
    $display("[TB] load 4,8 -> pc_out=%h", PC_out);

    step(1'b0, 64'hFC);
    check("mid_reset", PC_out, 64'h0);
    check("mid_reset_alt", PC_out_alt, ALT_VEC);
    $display("[TB] mid reset -> pc_out=%h", PC_out);

    step(1'b1, 64'h0000_0001_0000_0040);
    check("jump_64bit", PC_out, 64'h0000_0001_0000_0040);
    $display("[TB] jump -> pc_out=%h", PC_out);

    // Wiggle inputs between edges; output must hold its registered value.
    held = PC_out;
    rst = 1'b0; PC_in = 64'hDEAD_BEEF_0000_0000; #1;
    check("hold_rst_low", PC_out, held);
    rst = 1'b1; PC_in = 64'h1111_2222_3333_4444; #1;
    check("hold_pc_change", PC_out, held);
    rst = 1'b0; #1;
    check("hold_rst_toggle", PC_out, held);
    $display("[TB] between-edge toggles -> pc_out=%h", PC_out);

    step(1'b1, 64'h1111_2222_3333_4444);
    check("after_toggle_load", PC_out, 64'h1111_2222_3333_4444);

    step(1'b1, '1);
    check("all_ones", PC_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, '0);
    check("all_zeros", PC_out, 64'h0);
    $display("[TB] all-ones/all-zeros -> pc_out=%h", PC_out);

    // Recovery: first edge with rst=1 after reset loads normally.
    step(1'b0, 64'h55);
    step(1'b1, 64'hAA);
    check("resume_after_reset", PC_out, 64'hAA);

    for (int i = 0; i < 300; i++) begin
      logic         r;
      logic [N-1:0] v;
      r = ($urandom_range(0, 7) != 0);
      v = {$urandom, $urandom};
      exp_q.push_back(model_next(r, v, '0));
      exp_alt_q.push_back(model_next(r, v, ALT_VEC));
      step(r, v);
      check("rand", PC_out, exp_q.pop_front());
      check("rand_alt", PC_out_alt, exp_alt_q.pop_front());
      $display("[TB] rand %0d rst=%0b pc_in=%h pc_out=%h", i, r, v, PC_out);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter N, default 64: width in bits of the program counter.
REQ-002 Parameter RESET_VECTOR, default all-zeros (N bits): value loaded into the counter on reset.
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-005 Port PC_in, input, N bits: next program-counter value, computed externally (PC+4, branch or jump target).
REQ-006 Port PC_out, output, N bits: current registered program-counter value.

Function
REQ-007 The block SHALL contain one N-bit register driving PC_out directly, with no combinational path from PC_in or rst to PC_out.
REQ-008 On each rising clk edge with rst=1, the register SHALL load PC_in unmodified: no masking, alignment, increment or sign handling.
REQ-009 On each rising clk edge with rst=0, the register SHALL load RESET_VECTOR regardless of PC_in.
REQ-010 Latency: a value presented on PC_in before edge k SHALL appear on PC_out immediately after edge k and remain stable until edge k+1.
REQ-011 PC_out SHALL change only at rising clk edges; changes on PC_in or rst between edges SHALL have no effect on PC_out.
REQ-012 All N bits SHALL be stored, including the upper 32 bits when N=64 (e.g. 0x0000_0001_0000_0040 is held exactly).
REQ-013 There is no enable or stall input; the register SHALL update on every rising clk edge.
REQ-014 Reset asserted mid-sequence SHALL override any pending PC_in value on that edge, and normal loading SHALL resume on the first edge with rst=1.

Reset
REQ-015 Reset SHALL be purely synchronous; asserting rst=0 without a rising clk edge SHALL leave PC_out unchanged.
REQ-016 After the first rising edge with rst=0, PC_out SHALL equal RESET_VECTOR, which is 0 by default.
REQ-017 Before the first reset edge PC_out is undefined; users SHALL apply reset for at least one clk edge before relying on PC_out.

Verification (10 ns clock; each check sampled 1 ns after the rising edge)
REQ-018 rst=0 and PC_in=0x1234, one edge -> PC_out = 0x0000_0000_0000_0000.
REQ-019 rst=1 and PC_in=0x4, one edge -> PC_out = 0x4; then PC_in=0x8, one edge -> PC_out = 0x8.
REQ-020 rst=0 and PC_in=0xFC while PC_out=0x8, one edge -> PC_out = 0x0 (reset mid-operation).
REQ-021 rst=1 and PC_in=0x0000_0001_0000_0040, one edge -> PC_out = 0x0000_0001_0000_0040 (full 64-bit jump target).
REQ-022 Toggle PC_in and rst between edges -> PC_out keeps its last registered value until the next rising edge.
REQ-023 PC_in=all-ones then all-zeros with rst=1 -> PC_out = 0xFFFF_FFFF_FFFF_FFFF, then 0x0, with no wrap or truncation.
